// File: rtl/control_unit_pkg.sv
// Shared types for the Mini SRC control unit: opcodes, IR field
// positions, sequencer states, instruction classes, ALU strobes.
package control_unit_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;

  localparam logic [4:0]
    OPC_LD   = 5'd0,  OPC_LDI  = 5'd1,  OPC_ST   = 5'd2,
    OPC_ADD  = 5'd3,  OPC_SUB  = 5'd4,  OPC_AND  = 5'd5,
    OPC_OR   = 5'd6,  OPC_ROR  = 5'd7,  OPC_ROL  = 5'd8,
    OPC_SHR  = 5'd9,  OPC_SHRA = 5'd10, OPC_SHL  = 5'd11,
    OPC_ADDI = 5'd12, OPC_ANDI = 5'd13, OPC_ORI  = 5'd14,
    OPC_MUL  = 5'd15, OPC_DIV  = 5'd16, OPC_NEG  = 5'd17,
    OPC_NOT  = 5'd18, OPC_BR   = 5'd19, OPC_JR   = 5'd20,
    OPC_JAL  = 5'd21, OPC_IN   = 5'd22, OPC_OUT  = 5'd23,
    OPC_MFHI = 5'd24, OPC_MFLO = 5'd25, OPC_NOP  = 5'd26,
    OPC_HALT = 5'd27;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU_R, C_ALU_I, C_MULDIV, C_UNARY,
    C_LD, C_LDI, C_ST, C_BR, C_JR, C_JAL,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } iclass_t;

  typedef logic [12:0] alu_op_t;

  localparam alu_op_t OP_NONE = 13'h0000;
  localparam alu_op_t OP_ADD  = 13'h0001;
  localparam alu_op_t OP_SUB  = 13'h0002;
  localparam alu_op_t OP_AND  = 13'h0004;
  localparam alu_op_t OP_OR   = 13'h0008;
  localparam alu_op_t OP_SHR  = 13'h0010;
  localparam alu_op_t OP_SHRA = 13'h0020;
  localparam alu_op_t OP_SHL  = 13'h0040;
  localparam alu_op_t OP_ROR  = 13'h0080;
  localparam alu_op_t OP_ROL  = 13'h0100;
  localparam alu_op_t OP_MUL  = 13'h0200;
  localparam alu_op_t OP_DIV  = 13'h0400;
  localparam alu_op_t OP_NEG  = 13'h0800;
  localparam alu_op_t OP_NOT  = 13'h1000;

  typedef struct packed {
    logic    pc_out;
    logic    zlow_out;
    logic    zhigh_out;
    logic    mdr_out;
    logic    hi_out;
    logic    lo_out;
    logic    c_out;
    logic    ba_out;
    logic    inport_out;
    logic    pc_in;
    logic    ir_in;
    logic    mar_in;
    logic    mdr_in;
    logic    y_in;
    logic    z_in;
    logic    hi_in;
    logic    lo_in;
    logic    con_in;
    logic    outport_in;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    r_in;
    logic    r_out;
    logic    inc_pc;
    logic    read;
    logic    write;
    alu_op_t alu;
  } ctrl_t;

  // Final execute step of each class; nop/halt spend one idle T3.
  function automatic logic [2:0] last_step(iclass_t c);
    logic [2:0] s;
    case (c)
      C_ALU_R, C_ALU_I, C_LDI: s = 3'd5;
      C_MULDIV, C_ST, C_BR:    s = 3'd6;
      C_LD:                    s = 3'd7;
      C_UNARY, C_JAL:          s = 3'd4;
      default:                 s = 3'd3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: opcode -> instruction class and ALU strobe.
// Ports: opcode in; iclass, alu_op (one-hot or none) out.
module cu_decode
  import control_unit_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output alu_op_t    alu_op
);

  always_comb begin
    iclass = C_NOP;
    alu_op = OP_NONE;
    unique case (opcode)
      OPC_LD:   iclass = C_LD;
      OPC_LDI:  iclass = C_LDI;
      OPC_ST:   iclass = C_ST;
      OPC_ADD:  begin iclass = C_ALU_R;  alu_op = OP_ADD;  end
      OPC_SUB:  begin iclass = C_ALU_R;  alu_op = OP_SUB;  end
      OPC_AND:  begin iclass = C_ALU_R;  alu_op = OP_AND;  end
      OPC_OR:   begin iclass = C_ALU_R;  alu_op = OP_OR;   end
      OPC_ROR:  begin iclass = C_ALU_R;  alu_op = OP_ROR;  end
      OPC_ROL:  begin iclass = C_ALU_R;  alu_op = OP_ROL;  end
      OPC_SHR:  begin iclass = C_ALU_R;  alu_op = OP_SHR;  end
      OPC_SHRA: begin iclass = C_ALU_R;  alu_op = OP_SHRA; end
      OPC_SHL:  begin iclass = C_ALU_R;  alu_op = OP_SHL;  end
      OPC_ADDI: begin iclass = C_ALU_I;  alu_op = OP_ADD;  end
      OPC_ANDI: begin iclass = C_ALU_I;  alu_op = OP_AND;  end
      OPC_ORI:  begin iclass = C_ALU_I;  alu_op = OP_OR;   end
      OPC_MUL:  begin iclass = C_MULDIV; alu_op = OP_MUL;  end
      OPC_DIV:  begin iclass = C_MULDIV; alu_op = OP_DIV;  end
      OPC_NEG:  begin iclass = C_UNARY;  alu_op = OP_NEG;  end
      OPC_NOT:  begin iclass = C_UNARY;  alu_op = OP_NOT;  end
      OPC_BR:   iclass = C_BR;
      OPC_JR:   iclass = C_JR;
      OPC_JAL:  iclass = C_JAL;
      OPC_IN:   iclass = C_IN;
      OPC_OUT:  iclass = C_OUT;
      OPC_MFHI: iclass = C_MFHI;
      OPC_MFLO: iclass = C_MFLO;
      OPC_NOP:  iclass = C_NOP;
      OPC_HALT: iclass = C_HALT;
      default:  iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC Moore sequencer: fetch, decode, execute T3..T7.
// Ports: Clock, Clear (sync high), IR_In, BranchIn, Stop in;
// Run plus every datapath control strobe out.
// MULDIV_WAIT_EN: hold MUL/DIV T4 for MULDIV_CYCLES cycles.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR_In,
  input  logic        BranchIn,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        BAout,
  output logic        InPortout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        OutPortIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        MUL,
  output logic        DIV,
  output logic        NEG,
  output logic        NOT
);

  state_t     state_q, state_n;
  logic [2:0] step_q, step_n;
  iclass_t    cls_q, cls_n, dec_cls;
  alu_op_t    op_q, op_n, dec_op;
  logic       taken_q, taken_n;
  logic       hold;
  ctrl_t      c;
  logic       unused_ir;

  assign unused_ir = ^IR_In[OPC_LO-1:0];

  cu_decode u_dec (
    .opcode (IR_In[OPC_HI:OPC_LO]),
    .iclass (dec_cls),
    .alu_op (dec_op)
  );

`ifdef MULDIV_WAIT_EN
  logic [3:0] wait_q;

  always_ff @(posedge Clock) begin
    if (Clear)
      wait_q <= '0;
    else if (state_q == S_FETCH2)
      wait_q <= 4'(MULDIV_CYCLES);
    else if (hold)
      wait_q <= wait_q - 4'd1;
  end

  assign hold = (state_q == S_EXEC) &&
                (cls_q == C_MULDIV) &&
                (step_q == 3'd4) &&
                (wait_q > 4'd1);
`else
  logic [3:0] unused_cycles;

  assign unused_cycles = 4'(MULDIV_CYCLES);
  assign hold = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_RESET;
      step_q  <= '0;
      cls_q   <= C_NOP;
      op_q    <= OP_NONE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
      cls_q   <= cls_n;
      op_q    <= op_n;
      taken_q <= taken_n;
    end
  end

  // IR_In must carry the fetched word as FETCH2 completes;
  // the class is latched then so outputs stay register-driven.
  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    cls_n   = cls_q;
    op_n    = op_q;
    taken_n = taken_q;
    unique case (state_q)
      S_RESET:  state_n = S_FETCH0;
      S_FETCH0: state_n = S_FETCH1;
      S_FETCH1: state_n = S_FETCH2;
      S_FETCH2: begin
        state_n = S_EXEC;
        step_n  = 3'd3;
        cls_n   = dec_cls;
        op_n    = dec_op;
      end
      S_EXEC: begin
        // CON FF was loaded in T3; its value is stable by T5.
        if (step_q == 3'd5)
          taken_n = BranchIn;
        if (!hold) begin
          if (step_q == last_step(cls_q)) begin
            step_n  = '0;
            state_n = (cls_q == C_HALT || Stop) ?
                      S_HALT : S_FETCH0;
          end else begin
            step_n = step_q + 3'd1;
          end
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_RESET;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state_q)
      S_FETCH0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1;
        c.inc_pc = 1'b1; c.z_in   = 1'b1;
      end
      S_FETCH1: begin
        c.zlow_out = 1'b1; c.pc_in  = 1'b1;
        c.read     = 1'b1; c.mdr_in = 1'b1;
      end
      S_FETCH2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      S_EXEC: begin
        unique case (cls_q)
          C_ALU_R, C_ALU_I: begin
            case (step_q)
              3'd3: begin
                c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
              end
              3'd4: begin
                if (cls_q == C_ALU_I) begin
                  c.c_out = 1'b1;
                end else begin
                  c.grc = 1'b1; c.r_out = 1'b1;
                end
                c.alu  = op_q;
                c.z_in = 1'b1;
              end
              3'd5: begin
                c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
              end
              default: ;
            endcase
          end
          C_MULDIV: begin
            case (step_q)
              3'd3: begin
                c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
              end
              3'd4: begin
                c.grb  = 1'b1; c.r_out = 1'b1;
                c.alu  = op_q; c.z_in  = 1'b1;
              end
              3'd5: begin
                c.zlow_out = 1'b1; c.lo_in = 1'b1;
              end
              3'd6: begin
                c.zhigh_out = 1'b1; c.hi_in = 1'b1;
              end
              default: ;
            endcase
          end
          C_UNARY: begin
            case (step_q)
              3'd3: begin
                c.grb  = 1'b1; c.r_out = 1'b1;
                c.alu  = op_q; c.z_in  = 1'b1;
              end
              3'd4: begin
                c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
              end
              default: ;
            endcase
          end
          C_LD, C_LDI, C_ST: begin
            case (step_q)
              3'd3: begin
                c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
              end
              3'd4: begin
                c.c_out = 1'b1; c.alu = OP_ADD; c.z_in = 1'b1;
              end
              3'd5: begin
                c.zlow_out = 1'b1;
                if (cls_q == C_LDI) begin
                  c.gra = 1'b1; c.r_in = 1'b1;
                end else begin
                  c.mar_in = 1'b1;
                end
              end
              3'd6: begin
                if (cls_q == C_ST) begin
                  c.gra = 1'b1; c.r_out = 1'b1; c.write = 1'b1;
                end else begin
                  c.read = 1'b1; c.mdr_in = 1'b1;
                end
              end
              3'd7: begin
                c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
              end
              default: ;
            endcase
          end
          C_BR: begin
            case (step_q)
              3'd3: begin
                c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
              end
              3'd4: begin
                c.pc_out = 1'b1; c.y_in = 1'b1;
              end
              3'd5: begin
                c.c_out = 1'b1; c.alu = OP_ADD; c.z_in = 1'b1;
              end
              3'd6: begin
                c.zlow_out = taken_q; c.pc_in = taken_q;
              end
              default: ;
            endcase
          end
          C_JR: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
          end
          C_JAL: begin
            if (step_q == 3'd3) begin
              c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1;
            end else begin
              c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
            end
          end
          C_IN: begin
            c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          C_OUT: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1;
          end
          C_MFHI: begin
            c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          C_MFLO: begin
            c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Run = (state_q != S_RESET) && (state_q != S_HALT);

  assign {PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
          Cout, BAout, InPortout, PCin, IRin, MARin, MDRin,
          Yin, Zin, HIin, LOin, CONin, OutPortIn, Gra, Grb,
          Grc, Rin, Rout, IncPC, Read, Write} = c[39:13];

  assign {NOT, NEG, DIV, MUL, ROL, ROR, SHL, SHRA, SHR,
          OR, AND, SUB, ADD} = c.alu;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed traces plus
// random opcodes compared against a per-instruction step table.
module tb_control_unit;

  typedef logic [39:0] cv_t;

  localparam cv_t M_PCOUT     = cv_t'(1) << 0;
  localparam cv_t M_ZLOWOUT   = cv_t'(1) << 1;
  localparam cv_t M_ZHIGHOUT  = cv_t'(1) << 2;
  localparam cv_t M_MDROUT    = cv_t'(1) << 3;
  localparam cv_t M_HIOUT     = cv_t'(1) << 4;
  localparam cv_t M_LOOUT     = cv_t'(1) << 5;
  localparam cv_t M_COUT      = cv_t'(1) << 6;
  localparam cv_t M_BAOUT     = cv_t'(1) << 7;
  localparam cv_t M_INPORTOUT = cv_t'(1) << 8;
  localparam cv_t M_PCIN      = cv_t'(1) << 9;
  localparam cv_t M_IRIN      = cv_t'(1) << 10;
  localparam cv_t M_MARIN     = cv_t'(1) << 11;
  localparam cv_t M_MDRIN     = cv_t'(1) << 12;
  localparam cv_t M_YIN       = cv_t'(1) << 13;
  localparam cv_t M_ZIN       = cv_t'(1) << 14;
  localparam cv_t M_HIIN      = cv_t'(1) << 15;
  localparam cv_t M_LOIN      = cv_t'(1) << 16;
  localparam cv_t M_CONIN     = cv_t'(1) << 17;
  localparam cv_t M_OUTPORTIN = cv_t'(1) << 18;
  localparam cv_t M_GRA       = cv_t'(1) << 19;
  localparam cv_t M_GRB       = cv_t'(1) << 20;
  localparam cv_t M_GRC       = cv_t'(1) << 21;
  localparam cv_t M_RIN       = cv_t'(1) << 22;
  localparam cv_t M_ROUT      = cv_t'(1) << 23;
  localparam cv_t M_INCPC     = cv_t'(1) << 24;
  localparam cv_t M_READ      = cv_t'(1) << 25;
  localparam cv_t M_WRITE     = cv_t'(1) << 26;
  localparam cv_t M_ADD       = cv_t'(1) << 27;
  localparam cv_t M_SUB       = cv_t'(1) << 28;
  localparam cv_t M_AND       = cv_t'(1) << 29;
  localparam cv_t M_OR        = cv_t'(1) << 30;
  localparam cv_t M_SHR       = cv_t'(1) << 31;
  localparam cv_t M_SHRA      = cv_t'(1) << 32;
  localparam cv_t M_SHL       = cv_t'(1) << 33;
  localparam cv_t M_ROR       = cv_t'(1) << 34;
  localparam cv_t M_ROL       = cv_t'(1) << 35;
  localparam cv_t M_MUL       = cv_t'(1) << 36;
  localparam cv_t M_DIV       = cv_t'(1) << 37;
  localparam cv_t M_NEG       = cv_t'(1) << 38;
  localparam cv_t M_NOT       = cv_t'(1) << 39;

  localparam cv_t F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam cv_t F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam cv_t F2 = M_MDROUT | M_IRIN;

`ifdef MULDIV_WAIT_EN
  localparam int MD_T4 = 4;
`else
  localparam int MD_T4 = 1;
`endif

  logic        Clock = 1'b0;
  logic        Clear, BranchIn, Stop;
  logic [31:0] IR_In;
  logic Run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
  logic Cout, BAout, InPortout, PCin, IRin, MARin, MDRin;
  logic Yin, Zin, HIin, LOin, CONin, OutPortIn;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
  logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL;
  logic MUL, DIV, NEG, NOT;

  cv_t obs;
  assign obs = {NOT, NEG, DIV, MUL, ROL, ROR, SHL, SHRA, SHR,
                OR, AND, SUB, ADD, Write, Read, IncPC, Rout,
                Rin, Grc, Grb, Gra, OutPortIn, CONin, LOin,
                HIin, Zin, Yin, MDRin, MARin, IRin, PCin,
                InPortout, BAout, Cout, LOout, HIout, MDRout,
                Zhighout, Zlowout, PCout};

  int   npass = 0;
  int   ntotal = 0;
  int   nfail = 0;
  cv_t  exp_q[$];
  logic halted;

  control_unit #(.MULDIV_CYCLES(4)) dut (
    .Clock(Clock), .Clear(Clear), .IR_In(IR_In),
    .BranchIn(BranchIn), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .Cout(Cout), .BAout(BAout), .InPortout(InPortout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .CONin(CONin), .OutPortIn(OutPortIn), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR),
    .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [40:0] o,
                     input logic [40:0] e);
    ntotal++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic cv_t op_mask(input logic [4:0] opc);
    cv_t m;
    case (opc)
      5'd3, 5'd12: m = M_ADD;
      5'd4:        m = M_SUB;
      5'd5, 5'd13: m = M_AND;
      5'd6, 5'd14: m = M_OR;
      5'd7:        m = M_ROR;
      5'd8:        m = M_ROL;
      5'd9:        m = M_SHR;
      5'd10:       m = M_SHRA;
      5'd11:       m = M_SHL;
      5'd15:       m = M_MUL;
      5'd16:       m = M_DIV;
      5'd17:       m = M_NEG;
      5'd18:       m = M_NOT;
      default:     m = '0;
    endcase
    return m;
  endfunction

  // Expected control word for every cycle of one instruction.
  function automatic void build(input logic [4:0] opc,
                                input logic br);
    cv_t m;
    m = op_mask(opc);
    exp_q = {};
    exp_q.push_back(F0);
    exp_q.push_back(F1);
    exp_q.push_back(F2);
    if (opc >= 5'd3 && opc <= 5'd14) begin
      exp_q.push_back(M_GRB | M_ROUT | M_YIN);
      if (opc >= 5'd12)
        exp_q.push_back(M_COUT | m | M_ZIN);
      else
        exp_q.push_back(M_GRC | M_ROUT | m | M_ZIN);
      exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (opc == 5'd15 || opc == 5'd16) begin
      exp_q.push_back(M_GRA | M_ROUT | M_YIN);
      for (int k = 0; k < MD_T4; k++)
        exp_q.push_back(M_GRB | M_ROUT | m | M_ZIN);
      exp_q.push_back(M_ZLOWOUT | M_LOIN);
      exp_q.push_back(M_ZHIGHOUT | M_HIIN);
    end else if (opc == 5'd17 || opc == 5'd18) begin
      exp_q.push_back(M_GRB | M_ROUT | m | M_ZIN);
      exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (opc <= 5'd2) begin
      exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
      exp_q.push_back(M_COUT | M_ADD | M_ZIN);
      if (opc == 5'd1) begin
        exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN);
      end else begin
        exp_q.push_back(M_ZLOWOUT | M_MARIN);
        if (opc == 5'd0) begin
          exp_q.push_back(M_READ | M_MDRIN);
          exp_q.push_back(M_MDROUT | M_GRA | M_RIN);
        end else begin
          exp_q.push_back(M_GRA | M_ROUT | M_WRITE);
        end
      end
    end else if (opc == 5'd19) begin
      exp_q.push_back(M_GRA | M_ROUT | M_CONIN);
      exp_q.push_back(M_PCOUT | M_YIN);
      exp_q.push_back(M_COUT | M_ADD | M_ZIN);
      exp_q.push_back(br ? (M_ZLOWOUT | M_PCIN) : '0);
    end else if (opc == 5'd20) begin
      exp_q.push_back(M_GRA | M_ROUT | M_PCIN);
    end else if (opc == 5'd21) begin
      exp_q.push_back(M_PCOUT | M_GRB | M_RIN);
      exp_q.push_back(M_GRA | M_ROUT | M_PCIN);
    end else if (opc == 5'd22) begin
      exp_q.push_back(M_INPORTOUT | M_GRA | M_RIN);
    end else if (opc == 5'd23) begin
      exp_q.push_back(M_GRA | M_ROUT | M_OUTPORTIN);
    end else if (opc == 5'd24) begin
      exp_q.push_back(M_HIOUT | M_GRA | M_RIN);
    end else if (opc == 5'd25) begin
      exp_q.push_back(M_LOOUT | M_GRA | M_RIN);
    end else begin
      exp_q.push_back('0);
    end
  endfunction

  // Called with the DUT in FETCH0; leaves it in the next state.
  task automatic run_instr(input string tag,
                           input logic [31:0] ir,
                           input logic br, input logic stp,
                           output logic hlt);
    build(ir[31:27], br);
    IR_In = ir;
    BranchIn = br;
    Stop = stp;
    foreach (exp_q[i]) begin
      chk($sformatf("%s cyc%0d", tag, i), {Run, obs},
          {1'b1, exp_q[i]});
      tick();
    end
    Stop = 1'b0;
    hlt = (ir[31:27] == 5'd27) || stp;
    if (hlt)
      chk({tag, " halt"}, {Run, obs}, 41'd0);
    else
      chk({tag, " next"}, {Run, obs}, {1'b1, F0});
  endtask

  task automatic recover(input string tag);
    Clear = 1'b1;
    tick();
    chk({tag, " clear"}, {Run, obs}, 41'd0);
    Clear = 1'b0;
    tick();
    chk({tag, " restart"}, {Run, obs}, {1'b1, F0});
  endtask

  initial begin
    Clear = 1'b1;
    IR_In = '0;
    BranchIn = 1'b0;
    Stop = 1'b0;
    tick();
    tick();
    chk("reset", {Run, obs}, 41'd0);
    Clear = 1'b0;
    tick();
    chk("fetch0 after reset", {Run, obs}, {1'b1, F0});

    run_instr("add", 32'h19888000, 1'b0, 1'b0, halted);
    run_instr("br nt", {5'd19, 4'd5, 23'd0}, 1'b0, 1'b0, halted);
    run_instr("br t", {5'd19, 4'd5, 23'd0}, 1'b1, 1'b0, halted);
    run_instr("ld", {5'd0, 4'd1, 4'd0, 19'h55}, 1'b0, 1'b0,
              halted);
    run_instr("mul", {5'd15, 4'd4, 4'd6, 19'd0}, 1'b0, 1'b0,
              halted);
    run_instr("nop", {5'd26, 27'd0}, 1'b0, 1'b0, halted);

    build(5'd2, 1'b0);
    IR_In = {5'd2, 4'd3, 4'd1, 19'h10};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("st cyc%0d", i), {Run, obs},
          {1'b1, exp_q[i]});
      if (i == 4)
        Clear = 1'b1;
      tick();
    end
    chk("st cleared", {Run, obs}, 41'd0);
    Clear = 1'b0;
    tick();
    chk("st restart", {Run, obs}, {1'b1, F0});

    run_instr("add stop", 32'h19888000, 1'b0, 1'b1, halted);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stop held", {Run, obs}, 41'd0);
    end
    recover("stop");

    run_instr("halt", {5'd27, 27'd0}, 1'b0, 1'b0, halted);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt held", {Run, obs}, 41'd0);
    end
    recover("halt");

    for (int k = 0; k < 60; k++) begin
      logic [4:0]  opc;
      logic [31:0] ir;
      logic        br, stp;
      opc = 5'($urandom_range(0, 31));
      ir  = {opc, 27'($urandom)};
      br  = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 9) == 0);
      run_instr($sformatf("rand%0d op%0d", k, opc), ir, br, stp,
                halted);
      if (halted)
        recover($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
